// File: rtl/rv32_ctrl_pkg.sv
// Shared opcodes, state encoding and control codes for the
// multi-cycle RV32I control unit.
package rv32_ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_ALU_WB   = 4'd4,
    S_MEM_ADDR = 4'd5,
    S_MEM_RD   = 4'd6,
    S_MEM_WB   = 4'd7,
    S_MEM_WR   = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_JAL_WB   = 4'd12,
    S_LUI      = 4'd13,
    S_AUIPC    = 4'd14,
    S_ILLEGAL  = 4'd15
  } state_e;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_PASSB = 2'b11;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_RS1   = 2'b01;
  localparam logic [1:0] SRCA_OLDPC = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  function automatic state_e decode_next(input logic [6:0] op);
    state_e s;
    case (op)
      OP_R:      s = S_EXEC_R;
      OP_IMM:    s = S_EXEC_I;
      OP_LOAD:   s = S_MEM_ADDR;
      OP_STORE:  s = S_MEM_ADDR;
      OP_BRANCH: s = S_BRANCH;
      OP_JAL:    s = S_JAL;
      OP_JALR:   s = S_JALR;
      OP_LUI:    s = S_LUI;
      OP_AUIPC:  s = S_AUIPC;
      default:   s = S_ILLEGAL;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/multicycle_control_unit_ctrl_output_decode.sv
// State -> control vector decode; only the FETCH/MEM strobes
// and the branch PC write look at the live inputs.
module ctrl_output_decode
  import rv32_ctrl_pkg::*;
(
  input  logic [3:0] i_state,
  input  logic       i_zero,
  input  logic       i_mem_ready,
  output logic       o_pc_write,
  output logic       o_ir_write,
  output logic       o_addr_src,
  output logic       o_mem_read,
  output logic       o_mem_write,
  output logic       o_reg_write,
  output logic [1:0] o_alu_src_a,
  output logic [1:0] o_alu_src_b,
  output logic [1:0] o_alu_op,
  output logic [1:0] o_result_src,
  output logic       o_instr_done
);

  always_comb begin
    o_pc_write   = 1'b0;
    o_ir_write   = 1'b0;
    o_addr_src   = 1'b0;
    o_mem_read   = 1'b0;
    o_mem_write  = 1'b0;
    o_reg_write  = 1'b0;
    o_alu_src_a  = SRCA_PC;
    o_alu_src_b  = SRCB_RS2;
    o_alu_op     = ALU_ADD;
    o_result_src = RES_ALUOUT;
    o_instr_done = 1'b0;
    case (i_state)
      S_FETCH: begin
        o_mem_read  = 1'b1;
        o_ir_write  = i_mem_ready;
        o_pc_write  = i_mem_ready;
        o_alu_src_b = SRCB_FOUR;
      end
      S_DECODE: begin
        o_alu_src_a = SRCA_OLDPC;
        o_alu_src_b = SRCB_IMM;
      end
      S_EXEC_R: begin
        o_alu_src_a = SRCA_RS1;
        o_alu_op    = ALU_FUNCT;
      end
      S_EXEC_I: begin
        o_alu_src_a = SRCA_RS1;
        o_alu_src_b = SRCB_IMM;
        o_alu_op    = ALU_FUNCT;
      end
      S_ALU_WB, S_MEM_WB: begin
        o_reg_write  = 1'b1;
        o_instr_done = 1'b1;
        o_result_src = (i_state == S_MEM_WB) ? RES_MEM : RES_ALUOUT;
      end
      S_MEM_ADDR, S_JALR: begin
        o_alu_src_a = SRCA_RS1;
        o_alu_src_b = SRCB_IMM;
      end
      S_MEM_RD: begin
        o_mem_read = 1'b1;
        o_addr_src = 1'b1;
      end
      S_MEM_WR: begin
        o_mem_write  = 1'b1;
        o_addr_src   = 1'b1;
        o_instr_done = i_mem_ready;
      end
      S_BRANCH: begin
        o_alu_src_a  = SRCA_RS1;
        o_alu_op     = ALU_SUB;
        o_pc_write   = i_zero;
        o_instr_done = 1'b1;
      end
      S_JAL, S_JAL_WB: begin
        // link value is old PC + 4; PC loads the registered target
        o_alu_src_a  = SRCA_OLDPC;
        o_alu_src_b  = SRCB_FOUR;
        o_reg_write  = 1'b1;
        o_pc_write   = 1'b1;
        o_instr_done = 1'b1;
        o_result_src = (i_state == S_JAL) ? RES_ALU : RES_ALUOUT;
      end
      S_LUI: begin
        o_alu_src_a = SRCA_ZERO;
        o_alu_src_b = SRCB_IMM;
        o_alu_op    = ALU_PASSB;
      end
      S_AUIPC: begin
        o_alu_src_a = SRCA_OLDPC;
        o_alu_src_b = SRCB_IMM;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM with memory wait timeout.
// Define PERF_COUNTERS_EN to add cycle/instret counters.
module multicycle_control_unit
  import rv32_ctrl_pkg::*;
#(
  parameter int ALU_OP_W    = 2,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [6:0]          i_opcode,
  input  logic                i_zero,
  input  logic                i_mem_ready,
  output logic                o_pc_write,
  output logic                o_ir_write,
  output logic                o_addr_src,
  output logic                o_mem_read,
  output logic                o_mem_write,
  output logic                o_reg_write,
  output logic [1:0]          o_alu_src_a,
  output logic [1:0]          o_alu_src_b,
  output logic [ALU_OP_W-1:0] o_alu_op,
  output logic [1:0]          o_result_src,
  output logic                o_instr_done,
  output logic                o_error,
`ifdef PERF_COUNTERS_EN
  output logic [31:0]         o_cycle_count,
  output logic [31:0]         o_instret_count,
`endif
  output logic [3:0]          o_state
);

  localparam int CNT_W =
    (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam bit TO_EN = (MEM_TIMEOUT != 0);

  state_e     r_state;
  logic       r_error;
  logic [CNT_W-1:0] r_wait_cnt;

  logic w_pc_write, w_ir_write, w_mem_read;
  logic w_mem_write, w_reg_write, w_instr_done;
  logic [1:0] w_alu_op;
  logic w_wait_state, w_waiting, w_timeout;

  assign w_wait_state = (r_state == S_FETCH) ||
                        (r_state == S_MEM_RD) ||
                        (r_state == S_MEM_WR);
  assign w_waiting = w_wait_state && !i_mem_ready;
  assign w_timeout = TO_EN && w_waiting &&
    (r_wait_cnt == CNT_W'(MEM_TIMEOUT - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_FETCH;
      r_error    <= 1'b0;
      r_wait_cnt <= '0;
    end else if (w_timeout) begin
      r_state    <= S_ILLEGAL;
      r_error    <= 1'b1;
      r_wait_cnt <= '0;
    end else begin
      r_wait_cnt <= w_waiting ? r_wait_cnt + 1'b1 : '0;
      case (r_state)
        S_FETCH:
          if (i_mem_ready) r_state <= S_DECODE;
        S_DECODE: begin
          r_state <= decode_next(i_opcode);
          if (decode_next(i_opcode) == S_ILLEGAL)
            r_error <= 1'b1;
        end
        S_EXEC_R, S_EXEC_I, S_LUI, S_AUIPC:
          r_state <= S_ALU_WB;
        S_MEM_ADDR:
          r_state <= (i_opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
        S_MEM_RD:
          if (i_mem_ready) r_state <= S_MEM_WB;
        S_MEM_WR:
          if (i_mem_ready) r_state <= S_FETCH;
        S_JALR:
          r_state <= S_JAL_WB;
        S_ILLEGAL: begin
          r_state <= S_ILLEGAL;
          r_error <= 1'b1;
        end
        default:
          r_state <= S_FETCH;
      endcase
    end
  end

  ctrl_output_decode u_dec (
    .i_state      (r_state),
    .i_zero       (i_zero),
    .i_mem_ready  (i_mem_ready),
    .o_pc_write   (w_pc_write),
    .o_ir_write   (w_ir_write),
    .o_addr_src   (o_addr_src),
    .o_mem_read   (w_mem_read),
    .o_mem_write  (w_mem_write),
    .o_reg_write  (w_reg_write),
    .o_alu_src_a  (o_alu_src_a),
    .o_alu_src_b  (o_alu_src_b),
    .o_alu_op     (w_alu_op),
    .o_result_src (o_result_src),
    .o_instr_done (w_instr_done)
  );

  // enables are forced low while reset is held
  assign o_pc_write   = w_pc_write   & ~i_rst;
  assign o_ir_write   = w_ir_write   & ~i_rst;
  assign o_mem_read   = w_mem_read   & ~i_rst;
  assign o_mem_write  = w_mem_write  & ~i_rst;
  assign o_reg_write  = w_reg_write  & ~i_rst;
  assign o_instr_done = w_instr_done & ~i_rst;
  assign o_alu_op     = ALU_OP_W'(w_alu_op);
  assign o_error      = r_error;
  assign o_state      = r_state;

`ifdef PERF_COUNTERS_EN
  logic [31:0] r_cycle_count;
  logic [31:0] r_instret_count;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cycle_count   <= '0;
      r_instret_count <= '0;
    end else begin
      r_cycle_count <= r_cycle_count + 32'd1;
      if (w_instr_done)
        r_instret_count <= r_instret_count + 32'd1;
    end
  end

  assign o_cycle_count   = r_cycle_count;
  assign o_instret_count = r_instret_count;
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: latency table, directed
// corner sequences and a randomized instruction stream.
module tb_multicycle_control_unit;
  import rv32_ctrl_pkg::*;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic [6:0] i_opcode;
  logic       i_zero;
  logic       i_mem_ready;
  logic       o_pc_write, o_ir_write, o_addr_src;
  logic       o_mem_read, o_mem_write, o_reg_write;
  logic [1:0] o_alu_src_a, o_alu_src_b, o_alu_op;
  logic [1:0] o_result_src;
  logic       o_instr_done, o_error;
  logic [3:0] o_state;
`ifdef PERF_COUNTERS_EN
  logic [31:0] o_cycle_count, o_instret_count;
`endif

  multicycle_control_unit dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_opcode     (i_opcode),
    .i_zero       (i_zero),
    .i_mem_ready  (i_mem_ready),
    .o_pc_write   (o_pc_write),
    .o_ir_write   (o_ir_write),
    .o_addr_src   (o_addr_src),
    .o_mem_read   (o_mem_read),
    .o_mem_write  (o_mem_write),
    .o_reg_write  (o_reg_write),
    .o_alu_src_a  (o_alu_src_a),
    .o_alu_src_b  (o_alu_src_b),
    .o_alu_op     (o_alu_op),
    .o_result_src (o_result_src),
    .o_instr_done (o_instr_done),
    .o_error      (o_error),
`ifdef PERF_COUNTERS_EN
    .o_cycle_count   (o_cycle_count),
    .o_instret_count (o_instret_count),
`endif
    .o_state      (o_state)
  );

  always #5 i_clk = ~i_clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic next_cyc();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    repeat (2) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
  endtask

  // Latency table: one instruction, zero wait states
  typedef struct {
    logic [6:0] op;
    logic       zero;
    int         lat;
    logic       pcw;
    logic [1:0] rw;   // 2 = not checked
    logic [1:0] rs;   // 3 = not checked
  } vec_t;

  // Random-stream cycle record produced by the reference model
  typedef struct {
    logic [1:0] rdy;  // 2 = random, ignored by the unit
    logic       mrd, mwr, irw, done;
    logic [1:0] pcw;  // 2 = follows zero
    logic [1:0] rw;   // 2 = not checked
  } cyc_t;

  cyc_t q[$];

  function automatic cyc_t mk(input logic [1:0] rdy,
    input logic mrd, input logic mwr, input logic irw,
    input logic done, input logic [1:0] pcw,
    input logic [1:0] rw);
    cyc_t c;
    c.rdy = rdy; c.mrd = mrd; c.mwr = mwr; c.irw = irw;
    c.done = done; c.pcw = pcw; c.rw = rw;
    return c;
  endfunction

  // Expected cycle trace of one instruction from its class,
  // its latency and the wait states inserted on memory.
  task automatic build(input logic [6:0] op,
                       input int wf, input int wm);
    for (int i = 0; i < wf; i++)
      q.push_back(mk(0, 1, 0, 0, 0, 0, 0));
    q.push_back(mk(1, 1, 0, 1, 0, 1, 0));
    q.push_back(mk(2, 0, 0, 0, 0, 0, 0));
    case (op)
      OP_LOAD: begin
        q.push_back(mk(2, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < wm; i++)
          q.push_back(mk(0, 1, 0, 0, 0, 0, 0));
        q.push_back(mk(1, 1, 0, 0, 0, 0, 0));
        q.push_back(mk(2, 0, 0, 0, 1, 0, 1));
      end
      OP_STORE: begin
        q.push_back(mk(2, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < wm; i++)
          q.push_back(mk(0, 0, 1, 0, 0, 0, 0));
        q.push_back(mk(1, 0, 1, 0, 1, 0, 0));
      end
      OP_BRANCH: q.push_back(mk(2, 0, 0, 0, 1, 2, 0));
      OP_JAL:    q.push_back(mk(2, 0, 0, 0, 1, 1, 1));
      OP_JALR: begin
        q.push_back(mk(2, 0, 0, 0, 0, 0, 2));
        q.push_back(mk(2, 0, 0, 0, 1, 1, 2));
      end
      default: begin
        q.push_back(mk(2, 0, 0, 0, 0, 0, 0));
        q.push_back(mk(2, 0, 0, 0, 1, 0, 1));
      end
    endcase
  endtask

  task automatic run_cyc(input cyc_t c);
    logic [5:0] a, e;
    logic z;
    i_mem_ready = (c.rdy == 2'd2) ? 1'($urandom_range(0, 1))
                                  : c.rdy[0];
    z = 1'($urandom_range(0, 1));
    i_zero = z;
    @(negedge i_clk);
    e = {c.mrd, c.mwr, c.irw, c.done,
         (c.pcw == 2'd2) ? z : c.pcw[0], c.rw[0]};
    a = {o_mem_read, o_mem_write, o_ir_write, o_instr_done,
         o_pc_write, (c.rw == 2'd2) ? c.rw[0] : o_reg_write};
    chk("rand_cycle", 32'(a), 32'(e));
    next_cyc();
  endtask

  vec_t tbl[10];
  logic [6:0] ops[9];

  initial begin
    int cyc, rd_cnt, done_at;
    logic [6:0] op;

    tbl[0] = '{OP_R,      0, 4, 0, 1, 0};
    tbl[1] = '{OP_IMM,    0, 4, 0, 1, 0};
    tbl[2] = '{OP_LUI,    1, 4, 0, 1, 0};
    tbl[3] = '{OP_AUIPC,  0, 4, 0, 1, 0};
    tbl[4] = '{OP_LOAD,   0, 5, 0, 1, 1};
    tbl[5] = '{OP_STORE,  1, 4, 0, 0, 3};
    tbl[6] = '{OP_BRANCH, 1, 3, 1, 0, 0};
    tbl[7] = '{OP_BRANCH, 0, 3, 0, 0, 0};
    tbl[8] = '{OP_JAL,    0, 3, 1, 1, 2};
    tbl[9] = '{OP_JALR,   1, 4, 1, 2, 0};
    ops = '{OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH,
            OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};

    // reset: enables low while rst held, then FETCH / no error
    i_rst = 1'b1; i_mem_ready = 1'b1;
    i_zero = 1'b0; i_opcode = OP_R;
    @(posedge i_clk);
    @(negedge i_clk);
    chk("rst_enables", 32'({o_mem_read, o_mem_write,
        o_ir_write, o_pc_write, o_reg_write, o_instr_done}), 0);
    chk("rst_state", 32'(o_state), 32'(S_FETCH));
    chk("rst_error", 32'(o_error), 0);
    next_cyc();
    i_rst = 1'b0;

    // R-type state walk
    begin
      state_e exp_s[4];
      exp_s = '{S_FETCH, S_DECODE, S_EXEC_R, S_ALU_WB};
      for (int k = 0; k < 4; k++) begin
        @(negedge i_clk);
        chk("r_state", 32'(o_state), 32'(exp_s[k]));
        chk("r_regwr", 32'(o_reg_write), 32'(k == 3));
        chk("r_done", 32'(o_instr_done), 32'(k == 3));
        next_cyc();
      end
    end

    // latency table
    foreach (tbl[n]) begin
      i_opcode = tbl[n].op;
      i_zero = tbl[n].zero;
      i_mem_ready = 1'b1;
      done_at = 0;
      for (int k = 1; k <= 12 && done_at == 0; k++) begin
        @(negedge i_clk);
        if (o_instr_done) begin
          done_at = k;
          chk("tbl_pcw", 32'(o_pc_write), 32'(tbl[n].pcw));
          if (tbl[n].rw != 2'd2)
            chk("tbl_rw", 32'(o_reg_write), 32'(tbl[n].rw[0]));
          if (tbl[n].rs != 2'd3)
            chk("tbl_rs", 32'(o_result_src), 32'(tbl[n].rs));
        end
        next_cyc();
      end
      chk("tbl_lat", 32'(done_at), 32'(tbl[n].lat));
    end

    // load with 3 wait states in MEM_RD: 8 cycles total
    do_reset();
    i_opcode = OP_LOAD;
    rd_cnt = 0; done_at = 0;
    for (int k = 1; k <= 12 && done_at == 0; k++) begin
      i_mem_ready = !(k >= 4 && k <= 6);
      @(negedge i_clk);
      if (o_mem_read && o_addr_src) rd_cnt++;
      if (o_instr_done) begin
        done_at = k;
        chk("ld_regwr", 32'(o_reg_write), 1);
        chk("ld_rsrc", 32'(o_result_src), 32'(RES_MEM));
      end
      next_cyc();
    end
    chk("ld_rd_cycles", 32'(rd_cnt), 4);
    chk("ld_latency", 32'(done_at), 8);

    // rst during a memory wait drops the request
    do_reset();
    i_opcode = OP_LOAD; i_mem_ready = 1'b1;
    repeat (3) next_cyc();
    i_mem_ready = 1'b0;
    @(negedge i_clk);
    chk("mw_rd_req", 32'({o_mem_read, o_addr_src}), 3);
    next_cyc();
    i_rst = 1'b1;
    @(negedge i_clk);
    chk("mw_rd_drop", 32'({o_mem_read, o_mem_write}), 0);
    next_cyc();
    i_rst = 1'b0;
    @(negedge i_clk);
    chk("mw_state", 32'(o_state), 32'(S_FETCH));

    // illegal opcode: terminal and sticky
    do_reset();
    i_opcode = 7'b1111111; i_mem_ready = 1'b1;
    repeat (2) next_cyc();
    @(negedge i_clk);
    chk("ill_state", 32'(o_state), 32'(S_ILLEGAL));
    for (int k = 0; k < 5; k++) begin
      i_mem_ready = 1'($urandom_range(0, 1));
      i_opcode = OP_R;
      @(negedge i_clk);
      chk("ill_sticky", 32'({o_error, o_reg_write,
          o_mem_write}), 32'h4);
      next_cyc();
    end

    // memory timeout in FETCH
    do_reset();
    i_mem_ready = 1'b0;
    repeat (14) next_cyc();
    @(negedge i_clk);
    chk("to_14_err", 32'(o_error), 0);
    chk("to_14_state", 32'(o_state), 32'(S_FETCH));
    next_cyc();
    @(negedge i_clk);
    chk("to_15_err", 32'(o_error), 1);
    chk("to_15_state", 32'(o_state), 32'(S_ILLEGAL));
    next_cyc();
    i_rst = 1'b1;
    next_cyc();
    i_rst = 1'b0;
    @(negedge i_clk);
    chk("to_rst_state", 32'(o_state), 32'(S_FETCH));
    chk("to_rst_err", 32'(o_error), 0);

`ifdef PERF_COUNTERS_EN
    // R, load, store, branch back to back: 16 cycles
    do_reset();
    i_mem_ready = 1'b1;
    begin
      logic [6:0] pops[4];
      int plat[4];
      pops = '{OP_R, OP_LOAD, OP_STORE, OP_BRANCH};
      plat = '{4, 5, 4, 3};
      for (int n = 0; n < 4; n++) begin
        i_opcode = pops[n];
        repeat (plat[n]) next_cyc();
      end
    end
    @(negedge i_clk);
    chk("perf_instret", o_instret_count, 4);
    chk("perf_cycles", o_cycle_count, 16);
`endif

    // randomized stream against the trace model
    do_reset();
    for (int n = 0; n < 40; n++) begin
      op = ops[$urandom_range(0, 8)];
      i_opcode = op;
      build(op, $urandom_range(0, 4), $urandom_range(0, 4));
      while (q.size() > 0) run_cyc(q.pop_front());
    end
    @(negedge i_clk);
    chk("rand_no_error", 32'(o_error), 0);
    chk("rand_end_state", 32'(o_state), 32'(S_FETCH));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
